debounce_bank: RTL and testbench



---
 rtl/debounce_bank.sv | 171 +++++++++++++++++
 tb/tb_debounce_bank.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// N-channel button/switch debouncer: 2-flop synchroniser, stability counter,
// registered rise/fall strobes and a press strobe with optional auto-repeat.
module debounce_bank #(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 16384,
    parameter int IDLE_LEVEL    = 1,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 6000000,
    parameter int REPEAT_PERIOD = 1200000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    output logic [N-1:0] out,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] press,
    output logic         any_event
);

    localparam int CW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic          IDLE_L   = (IDLE_LEVEL != 0) ? 1'b1 : 1'b0;
    localparam logic          ACT_L    = ~IDLE_L;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_DELAY = 2'd1,
        R_RPT   = 2'd2,
        R_HELD  = 2'd3
    } rstate_t;

    logic [N-1:0] s1_r;
    logic [N-1:0] s0_r;

    // Two-flop synchroniser for the raw pad inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= {N{IDLE_L}};
            s0_r <= {N{IDLE_L}};
        end else begin
            s1_r <= in;
            s0_r <= s1_r;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [CW-1:0] cnt_r;
        logic [CW-1:0] cnt_nxt_s;
        logic          upd_s;
        logic          lvl_r;
        logic          rise_r;
        logic          fall_r;
        logic          press_r;
        logic          press_nxt_s;
        logic [RW-1:0] rcnt_r;
        logic [RW-1:0] rcnt_nxt_s;
        rstate_t       state_r;
        rstate_t       state_nxt_s;

        // Stability counter: any cycle where the input agrees with out restarts it
        always_comb begin
            cnt_nxt_s = '0;
            upd_s     = 1'b0;
            if (s0_r[i] != lvl_r) begin
                if (cnt_r == CNT_LAST) begin
                    upd_s     = 1'b1;
                    cnt_nxt_s = '0;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end else begin
                cnt_nxt_s = '0;
            end
        end

        // Debounced level and edge strobes
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r  <= '0;
                lvl_r  <= IDLE_L;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end else begin
                cnt_r  <= cnt_nxt_s;
                lvl_r  <= upd_s ? s0_r[i] : lvl_r;
                rise_r <= upd_s & s0_r[i];
                fall_r <= upd_s & ~s0_r[i];
            end
        end

        // Repeat FSM next state; an update while active is always a release
        always_comb begin
            state_nxt_s = state_r;
            rcnt_nxt_s  = rcnt_r;
            press_nxt_s = 1'b0;
            case (state_r)
                R_IDLE: begin
                    rcnt_nxt_s = '0;
                    if (upd_s && (s0_r[i] == ACT_L)) begin
                        press_nxt_s = 1'b1;
                        state_nxt_s = (REPEAT_EN != 0) ? R_DELAY : R_HELD;
                    end else begin
                        state_nxt_s = R_IDLE;
                    end
                end
                R_DELAY: begin
                    if (upd_s) begin
                        state_nxt_s = R_IDLE;
                        rcnt_nxt_s  = '0;
                    end else if (rcnt_r == DLY_LAST) begin
                        press_nxt_s = 1'b1;
                        rcnt_nxt_s  = '0;
                        state_nxt_s = R_RPT;
                    end else begin
                        rcnt_nxt_s = rcnt_r + RW'(1);
                    end
                end
                R_RPT: begin
                    if (upd_s) begin
                        state_nxt_s = R_IDLE;
                        rcnt_nxt_s  = '0;
                    end else if (rcnt_r == PER_LAST) begin
                        press_nxt_s = 1'b1;
                        rcnt_nxt_s  = '0;
                    end else begin
                        rcnt_nxt_s = rcnt_r + RW'(1);
                    end
                end
                R_HELD: begin
                    rcnt_nxt_s = '0;
                    if (upd_s) begin
                        state_nxt_s = R_IDLE;
                    end else begin
                        state_nxt_s = R_HELD;
                    end
                end
                default: begin
                    state_nxt_s = R_IDLE;
                    rcnt_nxt_s  = '0;
                end
            endcase
        end

        // Repeat FSM state, counter and press strobe
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r <= R_IDLE;
                rcnt_r  <= '0;
                press_r <= 1'b0;
            end else begin
                state_r <= state_nxt_s;
                rcnt_r  <= rcnt_nxt_s;
                press_r <= press_nxt_s;
            end
        end

        assign out[i]   = lvl_r;
        assign rise[i]  = rise_r;
        assign fall[i]  = fall_r;
        assign press[i] = press_r;
    end

    assign any_event = |(rise | fall);

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised scoreboard bench for debounce_bank; a repeat-enabled and a
// repeat-disabled instance share the same stimulus and reference model.
module tb_debounce_bank;

    localparam int   N    = 4;
    localparam int   S    = 8;
    localparam int   D    = 20;
    localparam int   P    = 5;
    localparam logic IDLE = 1'b1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] in;
    logic [N-1:0] out_a, rise_a, fall_a, press_a;
    logic [N-1:0] out_b, rise_b, fall_b, press_b;
    logic         any_a, any_b;

    initial forever #5 clk = ~clk;

    debounce_bank #(.N(N), .STABLE_CYCLES(S), .IDLE_LEVEL(1), .REPEAT_EN(1),
                    .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) u_rep (
        .clk(clk), .rst_n(rst_n), .in(in), .out(out_a), .rise(rise_a),
        .fall(fall_a), .press(press_a), .any_event(any_a));

    debounce_bank #(.N(N), .STABLE_CYCLES(S), .IDLE_LEVEL(1), .REPEAT_EN(0),
                    .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) u_norep (
        .clk(clk), .rst_n(rst_n), .in(in), .out(out_b), .rise(rise_b),
        .fall(fall_b), .press(press_b), .any_event(any_b));

    typedef struct packed {
        logic [N-1:0] out;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] press;
        logic [N-1:0] press_nr;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: pin delay line, age of the current synchronised level,
    // accepted level, and the cycle of the initial press per channel.
    logic [N-1:0] m_s1, m_s0, m_prev, m_out;
    int           m_age[N];
    int           m_t0[N];
    int           m_cyc = 0;

    task automatic model_reset();
        m_s1   = {N{IDLE}};
        m_s0   = {N{IDLE}};
        m_prev = {N{IDLE}};
        m_out  = {N{IDLE}};
        for (int i = 0; i < N; i++) begin
            m_age[i] = 0;
            m_t0[i]  = -1;
        end
    endtask

    function automatic exp_t reset_vec();
        exp_t e;
        e     = '0;
        e.out = {N{IDLE}};
        return e;
    endfunction

    task automatic model_step();
        exp_t e;
        e = '0;
        if (!rst_n) begin
            model_reset();
            e = reset_vec();
        end else begin
            for (int i = 0; i < N; i++) begin
                logic v;
                int   d;
                v         = m_s0[i];
                m_age[i]  = (v == m_prev[i]) ? m_age[i] + 1 : 1;
                m_prev[i] = v;
                if ((v != m_out[i]) && (m_age[i] >= S)) begin
                    m_out[i]  = v;
                    e.rise[i] = v;
                    e.fall[i] = ~v;
                    if (v != IDLE) begin
                        e.press[i]    = 1'b1;
                        e.press_nr[i] = 1'b1;
                        m_t0[i]       = m_cyc;
                    end else begin
                        m_t0[i] = -1;
                    end
                end else if (m_t0[i] >= 0) begin
                    d = m_cyc - m_t0[i];
                    if ((d >= D) && (((d - D) % P) == 0)) e.press[i] = 1'b1;
                end
            end
            e.out = m_out;
            m_s0  = m_s1;
            m_s1  = in;
        end
        m_cyc++;
        sb_q.push_back(e);
    endtask

    task automatic cycle(input logic [N-1:0] v);
        @(posedge clk);
        model_step();
        #2 in = v;
    endtask

    task automatic hold(input logic [N-1:0] v, input int n);
        repeat (n) cycle(v);
    endtask

    // Asynchronous reset pulse entirely between two rising edges
    task automatic reset_pulse();
        @(posedge clk);
        model_step();
        #2 rst_n = 1'b0;
        model_reset();
        sb_q.delete();
        sb_q.push_back(reset_vec());
        #5 rst_n = 1'b1;
    endtask

    // Monitor: one expected vector per cycle, compared on the falling edge
    initial forever begin
        @(negedge clk);
        if (sb_q.size() > 0) begin
            exp_t e;
            logic ok;
            e  = sb_q.pop_front();
            ok = (out_a === e.out) && (rise_a === e.rise) && (fall_a === e.fall) &&
                 (press_a === e.press) && (any_a === |(e.rise | e.fall)) &&
                 (out_b === e.out) && (rise_b === e.rise) && (fall_b === e.fall) &&
                 (press_b === e.press_nr) && (any_b === |(e.rise | e.fall));
            vectors++;
            if (!ok) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("FAIL scoreboard vec=%0d t=%0t got out=%b rise=%b fall=%b press=%b any=%b nr_out=%b nr_press=%b nr_any=%b exp out=%b rise=%b fall=%b press=%b nr_press=%b",
                             vectors, $time, out_a, rise_a, fall_a, press_a, any_a,
                             out_b, press_b, any_b, e.out, e.rise, e.fall, e.press, e.press_nr);
            end
        end
    end

    initial begin
        in    = '0;
        rst_n = 1'b0;
        model_reset();
        hold(4'b0000, 3);
        @(negedge clk);
        #1 rst_n = 1'b1;
        hold(4'b0000, 15);
        hold(4'b1111, 15);
        hold(4'b1110, 15);
        hold(4'b1111, 12);
        hold(4'b1101, 7);
        hold(4'b1111, 12);
        hold(4'b1101, 8);
        hold(4'b1111, 14);
        hold(4'b1011, 72);
        hold(4'b1111, 15);
        hold(4'b0111, 7);
        reset_pulse();
        hold(4'b0111, 15);
        hold(4'b1111, 12);
        hold(4'b1110, 100);
        hold(4'b1111, 12);
        for (int seg = 0; seg < 8; seg++) begin
            int rate;
            rate = $urandom_range(4, 80);
            for (int c = 0; c < 250; c++) begin
                logic [N-1:0] nv;
                nv = in;
                for (int b = 0; b < N; b++)
                    if ($urandom_range(0, rate - 1) == 0) nv[b] = ~nv[b];
                if ($urandom_range(0, 399) == 0) reset_pulse();
                else cycle(nv);
            end
        end
        repeat (3) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
